// File: rtl/serial_cmp_pkg.sv
// Shared state encoding, default frame length and counter-width helper for
// the bit-serial frame comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_FRAME_LEN = 8;

  // Width that can hold every value 0..frame_len, so the mismatch count never wraps.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/bit_mismatch_mux.sv
// Per-bit mismatch (a XOR b) built as a 2:1 mux selected by a, matching
// the mux-based gate construction of the upstream XOR/XNOR stage.
module bit_mismatch_mux (
  input  logic a,
  input  logic b,
  output logic mismatch
);

  assign mismatch = a ? ~b : b;

endmodule

// File: rtl/serial_xor_comparator.sv
// Bit-serial frame comparator: counts a!=b pairs over FRAME_LEN valid bits.
// Optional first-mismatch capture enabled by defining SERIAL_CMP_FIRST_IDX_EN.
module serial_xor_comparator
  import serial_cmp_pkg::*;
#(
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic             equal,
`ifdef SERIAL_CMP_FIRST_IDX_EN
  output logic [CNT_W-1:0] first_mismatch_idx,
  output logic             any_mismatch,
`endif
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] bit_idx;
  logic [CNT_W-1:0] cnt_q;
  logic             equal_q;
  logic             mis;
  logic             accept_start;
  logic             sample;
  logic             last_bit;

  bit_mismatch_mux u_mis (
    .a        (a),
    .b        (b),
    .mismatch (mis)
  );

  assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign sample       = (state_q == ST_RUN) && bit_valid;
  assign last_bit     = sample && (bit_idx == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_idx <= '0;
      cnt_q   <= '0;
      equal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        bit_idx <= '0;
        cnt_q   <= '0;
        equal_q <= 1'b0;
      end else if (sample) begin
        bit_idx <= bit_idx + 1'b1;
        cnt_q   <= cnt_q + CNT_W'(mis);
        // Equality is resolved on the final-bit edge so it is valid during DONE.
        if (last_bit) equal_q <= (cnt_q == '0) && !mis;
      end
    end
  end

`ifdef SERIAL_CMP_FIRST_IDX_EN
  logic [CNT_W-1:0] first_idx_q;
  logic             any_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_idx_q <= '0;
      any_q       <= 1'b0;
    end else if (accept_start) begin
      first_idx_q <= '0;
      any_q       <= 1'b0;
    end else if (sample && mis && !any_q) begin
      first_idx_q <= bit_idx;
      any_q       <= 1'b1;
    end
  end

  assign first_mismatch_idx = first_idx_q;
  assign any_mismatch       = any_q;
`endif

  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign equal        = equal_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_serial_xor_comparator.sv
// Directed bench for serial_xor_comparator (FRAME_LEN=8) with hand-computed
// expectations; first-mismatch outputs are checked when SERIAL_CMP_FIRST_IDX_EN is defined.
module tb_serial_xor_comparator;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             bit_valid;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             equal;
  logic [CNT_W-1:0] mismatch_cnt;
`ifdef SERIAL_CMP_FIRST_IDX_EN
  logic [CNT_W-1:0] first_mismatch_idx;
  logic             any_mismatch;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_xor_comparator #(.FRAME_LEN(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .bit_valid          (bit_valid),
    .a                  (a),
    .b                  (b),
    .busy               (busy),
    .done               (done),
    .equal              (equal),
`ifdef SERIAL_CMP_FIRST_IDX_EN
    .first_mismatch_idx (first_mismatch_idx),
    .any_mismatch       (any_mismatch),
`endif
    .mismatch_cnt       (mismatch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_first(input string tag, input int idx, input logic any);
`ifdef SERIAL_CMP_FIRST_IDX_EN
    check({tag, "_first_idx"}, 32'(first_mismatch_idx), 32'(idx));
    check({tag, "_any"}, 32'(any_mismatch), 32'(any));
`endif
  endtask

  task automatic start_pulse(input logic bv, input logic av, input logic bbit);
    start = 1'b1; bit_valid = bv; a = av; b = bbit;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0;
  endtask

  // Sends 8 bits MSB first; stalls 3 cycles before bit stall_at, pulses start with bit restart_at.
  // Returns at the negedge of the DONE cycle.
  task automatic send_frame(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input int stall_at, input int restart_at);
    logic early;
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        bit_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          early |= done | ~busy;
        end
      end
      bit_valid = 1'b1; a = av[7-i]; b = bv[7-i];
      start = (i == restart_at);
      @(negedge clk);
      if (i < 7) early |= done | ~busy;
    end
    bit_valid = 1'b0; start = 1'b0;
    check({tag, "_no_early_done"}, 32'(early), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_equal", 32'(equal), 32'd0);
    check("rst_cnt", 32'(mismatch_cnt), 32'd0);
    check_first("rst", 0, 1'b0);

    // bit_valid activity in IDLE must be ignored
    for (int i = 0; i < 4; i++) begin
      bit_valid = i[0]; a = 1'b1; b = i[1];
      @(negedge clk);
    end
    bit_valid = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_cnt", 32'(mismatch_cnt), 32'd0);

    // Start with a mismatching valid pair on the same cycle: pair not sampled
    start_pulse(1'b1, 1'b1, 1'b0);
    check("f1_busy", 32'(busy), 32'd1);
    send_frame("f1", 8'b10110010, 8'b10110010, 99, 99);
    check("f1_equal", 32'(equal), 32'd1);
    check("f1_cnt", 32'(mismatch_cnt), 32'd0);
    check_first("f1", 0, 1'b0);
    @(negedge clk);
    check("f1_done_drop", 32'(done), 32'd0);

    // Stall mid-frame; mismatches at bit 2 and bit 7
    start_pulse(1'b0, 1'b0, 1'b0);
    send_frame("f2", 8'b10110010, 8'b10010011, 4, 99);
    check("f2_equal", 32'(equal), 32'd0);
    check("f2_cnt", 32'(mismatch_cnt), 32'd2);
    check_first("f2", 2, 1'b1);
    repeat (3) @(negedge clk);
    check("f2_hold_cnt", 32'(mismatch_cnt), 32'd2);
    check("f2_hold_done", 32'(done), 32'd0);
    check_first("f2_hold", 2, 1'b1);

    // All bits differ; start during RUN is ignored
    start_pulse(1'b0, 1'b0, 1'b0);
    send_frame("f3", 8'hFF, 8'h00, 99, 3);
    check("f3_equal", 32'(equal), 32'd0);
    check("f3_cnt", 32'(mismatch_cnt), 32'd8);
    check_first("f3", 0, 1'b1);

    // Back-to-back: start in the DONE cycle
    start_pulse(1'b0, 1'b0, 1'b0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_cleared_cnt", 32'(mismatch_cnt), 32'd0);
    check("b2b_cleared_equal", 32'(equal), 32'd0);
    send_frame("f4", 8'h5A, 8'h5A, 99, 99);
    check("f4_equal", 32'(equal), 32'd1);
    check("f4_cnt", 32'(mismatch_cnt), 32'd0);
    check_first("f4", 0, 1'b0);
    @(negedge clk);

    // Reset after the 4th valid bit aborts the frame
    start_pulse(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; a = 1'b1; b = 1'b0;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    check("pre_abort_cnt", 32'(mismatch_cnt), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_cnt", 32'(mismatch_cnt), 32'd0);
    check("abort_equal", 32'(equal), 32'd0);
    check_first("abort", 0, 1'b0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        bit_valid = 1'b1; a = 1'b1; b = 1'b0;
        @(negedge clk);
        seen |= done | busy;
      end
      bit_valid = 1'b0;
      check("abort_stays_idle", 32'(seen), 32'd0);
    end

    // Fresh frame after abort: single mismatch on the last bit
    start_pulse(1'b0, 1'b0, 1'b0);
    send_frame("f5", 8'h0F, 8'h0E, 99, 99);
    check("f5_equal", 32'(equal), 32'd0);
    check("f5_cnt", 32'(mismatch_cnt), 32'd1);
    check_first("f5", 7, 1'b1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
